// File: rtl/pipelined_wallace_adder.sv
// Pipelined multi-operand adder: registered 3:2 carry-save levels followed by a registered carry-propagate adder.
// Optional macro WALLACE_RESULT_CNT_EN adds a 16-bit output-transfer counter port result_cnt.
module pipelined_wallace_adder #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 6,
  parameter int SIGNED   = 0,
  localparam int OW      = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OW-1:0]             out_sum,
  output logic                      busy
`ifdef WALLACE_RESULT_CNT_EN
  ,
  output logic [15:0]               result_cnt
`endif
);

  function automatic int next_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = CHANNELS;
    for (int i = 0; i < lvl; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int num_stages(input int n);
    int s;
    int r;
    s = 0;
    r = n;
    while (r > 2) begin
      r = next_rows(r);
      s++;
    end
    return s;
  endfunction

  localparam int STAGES = num_stages(CHANNELS);

  logic          adv;
  logic [OW-1:0] ext [CHANNELS];
  logic [OW-1:0] row_a;
  logic [OW-1:0] row_b;
  logic          last_valid;
  logic [OW-1:0] sum_d;

  // Global stall: every stage moves together, so occupancy only changes at the ends.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op     = in_data[k*WIDTH +: WIDTH];
    assign ext[k] = (SIGNED != 0) ? {{(OW-WIDTH){op[WIDTH-1]}}, op}
                                  : {{(OW-WIDTH){1'b0}}, op};
  end

  if (STAGES == 0) begin : g_notree
    assign row_a      = ext[0];
    assign row_b      = ext[1];
    assign last_valid = in_valid;
    assign busy       = out_valid;
  end else begin : g_tree
    logic [OW-1:0]     lvl_q [STAGES][CHANNELS];
    logic [OW-1:0]     lvl_d [STAGES][CHANNELS];
    logic [STAGES-1:0] vld;

    // Each level reads the previous level's registers; rows beyond the live count stay zero.
    always_comb begin
      logic [OW-1:0] src [CHANNELS];
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic [OW-1:0] c;
      int            n;
      int            ncsa;
      lvl_d = '{default: '0};
      src   = '{default: '0};
      a     = '0;
      b     = '0;
      c     = '0;
      n     = 0;
      ncsa  = 0;
      for (int l = 0; l < STAGES; l++) begin
        n    = rows_at(l);
        ncsa = n / 3;
        for (int j = 0; j < CHANNELS; j++)
          src[j] = (l == 0) ? ext[j] : lvl_q[(l == 0) ? 0 : l - 1][j];
        for (int g = 0; g < ncsa; g++) begin
          a = src[3*g];
          b = src[3*g+1];
          c = src[3*g+2];
          lvl_d[l][2*g]   = a ^ b ^ c;
          lvl_d[l][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
        end
        for (int r = 0; r < n % 3; r++)
          lvl_d[l][2*ncsa+r] = src[3*ncsa+r];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_q <= '{default: '0};
        vld   <= '0;
      end else if (adv) begin
        lvl_q  <= lvl_d;
        vld[0] <= in_valid;
        for (int s = 1; s < STAGES; s++) vld[s] <= vld[s-1];
      end
    end

    assign row_a      = lvl_q[STAGES-1][0];
    assign row_b      = lvl_q[STAGES-1][1];
    assign last_valid = vld[STAGES-1];
    assign busy       = (|vld) || out_valid;
  end

  assign sum_d = row_a + row_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (adv) begin
      out_valid <= last_valid;
      out_sum   <= sum_d;
    end
  end

`ifdef WALLACE_RESULT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) result_cnt <= '0;
    else if (out_valid && out_ready) result_cnt <= result_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipelined_wallace_adder.sv
// Scoreboard bench for pipelined_wallace_adder: random streams with backpressure checked against arithmetic sums,
// plus latency/max-value checks on CHANNELS=2/3/9 instances; result_cnt checked when WALLACE_RESULT_CNT_EN is set.
module tb_pipelined_wallace_adder;
  localparam int W  = 10;
  localparam int C  = 6;
  localparam int OW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid;
  logic            out_ready;
  logic [C*W-1:0]  in_data;
  logic            in_ready, out_valid, busy;
  logic [OW-1:0]   out_sum;
  logic            s_in_ready, s_out_valid, s_busy;
  logic [OW-1:0]   s_out_sum;

  logic            e_valid;
  logic            e_ready;
  logic [2*W-1:0]  e2_data;
  logic [3*W-1:0]  e3_data;
  logic [9*W-1:0]  e9_data;
  logic            e2_ir, e2_ov, e2_busy, e3_ir, e3_ov, e3_busy, e9_ir, e9_ov, e9_busy;
  logic [10:0]     e2_sum;
  logic [11:0]     e3_sum;
  logic [13:0]     e9_sum;
`ifdef WALLACE_RESULT_CNT_EN
  logic [15:0]     cnt_u, cnt_s, cnt_2, cnt_3, cnt_9;
`endif

  pipelined_wallace_adder #(.WIDTH(W), .CHANNELS(C), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
`ifdef WALLACE_RESULT_CNT_EN
    , .result_cnt(cnt_u)
`endif
  );

  pipelined_wallace_adder #(.WIDTH(W), .CHANNELS(C), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum), .busy(s_busy)
`ifdef WALLACE_RESULT_CNT_EN
    , .result_cnt(cnt_s)
`endif
  );

  pipelined_wallace_adder #(.WIDTH(W), .CHANNELS(2), .SIGNED(0)) u_e2 (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e2_ir), .in_data(e2_data),
    .out_valid(e2_ov), .out_ready(e_ready), .out_sum(e2_sum), .busy(e2_busy)
`ifdef WALLACE_RESULT_CNT_EN
    , .result_cnt(cnt_2)
`endif
  );

  pipelined_wallace_adder #(.WIDTH(W), .CHANNELS(3), .SIGNED(0)) u_e3 (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e3_ir), .in_data(e3_data),
    .out_valid(e3_ov), .out_ready(e_ready), .out_sum(e3_sum), .busy(e3_busy)
`ifdef WALLACE_RESULT_CNT_EN
    , .result_cnt(cnt_3)
`endif
  );

  pipelined_wallace_adder #(.WIDTH(W), .CHANNELS(9), .SIGNED(0)) u_e9 (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e9_ir), .in_data(e9_data),
    .out_valid(e9_ov), .out_ready(e_ready), .out_sum(e9_sum), .busy(e9_busy)
`ifdef WALLACE_RESULT_CNT_EN
    , .result_cnt(cnt_9)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_u[$];
  logic [OW-1:0] exp_s[$];
  int xfer_cnt = 0;
  logic have_prev = 1'b0;
  logic prev_stall = 1'b0;
  logic [OW-1:0] prev_sum = '0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [OW-1:0] refUnsigned(input logic [C*W-1:0] d);
    int s;
    logic [31:0] t;
    s = 0;
    for (int k = 0; k < C; k++) s += int'(d[k*W +: W]);
    t = s;
    return t[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] refSigned(input logic [C*W-1:0] d);
    int s;
    int v;
    logic [31:0] t;
    s = 0;
    for (int k = 0; k < C; k++) begin
      v = $signed(d[k*W +: W]);
      s += v;
    end
    t = s;
    return t[OW-1:0];
  endfunction

  function automatic logic [C*W-1:0] randData();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 9) == 0) r = '1;
    return r[C*W-1:0];
  endfunction

  // Monitor: records input transfers into the scoreboard and checks every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_u.delete();
      exp_s.delete();
      xfer_cnt  = 0;
      have_prev = 1'b0;
    end else begin
      checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
      checkOutput("s_in_ready_rule", s_in_ready, !s_out_valid || out_ready);
      if (have_prev && prev_stall) checkOutput("stall_hold", out_sum, prev_sum);
      if (in_valid && in_ready) begin
        exp_u.push_back(refUnsigned(in_data));
        exp_s.push_back(refSigned(in_data));
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_u.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sum_u: got %0d expected no result", out_sum);
        end else checkOutput("sum_u", out_sum, exp_u.pop_front());
      end
      if (s_out_valid && out_ready) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sum_s: got %0d expected no result", s_out_sum);
        end else checkOutput("sum_s", s_out_sum, exp_s.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      have_prev  = 1'b1;
    end
  end

  task automatic applyStimulus(input logic v, input logic [C*W-1:0] d, input logic r);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_u.size() != 0 || exp_s.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_u_empty", exp_u.size(), 0);
    checkOutput("drain_s_empty", exp_s.size(), 0);
  endtask

  initial begin
    int lat;
    int l2, l3, l9;
    logic [13:0] s2, s3, s9;
    logic hold;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    e_valid = 1'b0; e_ready = 1'b1; e2_data = '1; e3_data = '1; e9_data = '1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_sum", out_sum, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    #1 rst = 1'b0;

    // All operands at max: unsigned 6138, signed -6, with latency STAGES+1.
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = {C{10'h3FF}}; out_ready = 1'b1;
    lat = 0;
    for (int cyc = 1; cyc <= 12 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = cyc;
        checkOutput("max_sum_u", out_sum, 13'h17FA);
        checkOutput("max_sum_s", s_out_sum, 13'h1FFA);
      end
    end
    checkOutput("latency_6ch", lat, 4);

    applyStimulus(1'b1, {40'h0, 10'h200, 10'h1FF}, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    drain();

    for (int i = 0; i < 100; i++) applyStimulus(1'b1, randData(), 1'b1);
    drain();

    // Backpressure: producer holds data while not accepted.
    for (int i = 0; i < 300; i++) begin
      hold = in_valid && !in_ready;
      @(posedge clk); #2;
      if (!hold) begin
        in_valid = ($urandom_range(0, 99) < 70);
        in_data  = randData();
      end
      out_ready = ($urandom_range(0, 99) >= 30);
    end
    drain();

    // Reset with three sets in flight.
    applyStimulus(1'b1, randData(), 1'b1);
    applyStimulus(1'b1, randData(), 1'b1);
    applyStimulus(1'b1, randData(), 1'b1);
    @(posedge clk); #1;
    checkOutput("busy_before_reset", busy, 1);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_sum", out_sum, 0);
    checkOutput("midrst_s_busy", s_busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      hold = in_valid && !in_ready;
      @(posedge clk); #2;
      if (!hold) begin
        in_valid = ($urandom_range(0, 99) < 70);
        in_data  = randData();
      end
      out_ready = ($urandom_range(0, 99) >= 30);
    end
    drain();
`ifdef WALLACE_RESULT_CNT_EN
    checkOutput("result_cnt", cnt_u, xfer_cnt);
`endif

    // Edge channel counts with all-ones operands.
    @(posedge clk); #2;
    e_valid = 1'b1;
    l2 = 0; l3 = 0; l9 = 0; s2 = '0; s3 = '0; s9 = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) e_valid = 1'b0;
      if (e2_ov && l2 == 0) begin l2 = cyc; s2 = 14'(e2_sum); end
      if (e3_ov && l3 == 0) begin l3 = cyc; s3 = 14'(e3_sum); end
      if (e9_ov && l9 == 0) begin l9 = cyc; s9 = e9_sum; end
    end
    checkOutput("latency_2ch", l2, 1);
    checkOutput("latency_3ch", l3, 2);
    checkOutput("latency_9ch", l9, 5);
    checkOutput("sum_2ch", s2, 2046);
    checkOutput("sum_3ch", s3, 3069);
    checkOutput("sum_9ch", s9, 9207);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_wallace_adder.md
# pipelined_wallace_adder

Parametrised, pipelined multi-operand adder: reduces `CHANNELS` operands of `WIDTH` bits through 3:2 carry-save levels, each registered, then a registered carry-propagate adder to one full-precision sum. It succeeds the combinational carry-save tree in the adder library. It adds a valid/ready stream interface, full throughput of one operand set per cycle, backpressure, signed/unsigned mode, and a final sum in place of carry/sum row pairs. It sits between operand producers (partial-product generators, accumulator fabrics) and downstream datapath consumers.

## Interface
- `WIDTH`, 10, bits per operand (≥2)
- `CHANNELS`, 6, number of operands (2..32)
- `SIGNED`, 0, 1 = operands are two's complement and are sign-extended; 0 = zero-extended
- Derived `OW` = `WIDTH + $clog2(CHANNELS)`: output width.
- Derived `STAGES`: number of 3:2 levels needed to reach 2 rows. Each level maps n rows to 2·⌊n/3⌋ + n mod 3. Examples: 2→0, 3→1, 4→2, 5..6→3, 7..9→4.
- `clk`  in  1  clock. Everything is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  operand set valid
- `in_ready`  out  1  block accepts operand set this cycle
- `in_data`  in  CHANNELS*WIDTH  packed operands; channel k = `in_data[k*WIDTH +: WIDTH]`
- `out_valid`  out  1  `out_sum` valid
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  OW  sum of all channels, exact modulo 2^OW
- `busy`  out  1  any pipeline stage holds valid data

## Operation
- Operands are extended to `OW` bits on input: sign-extended if `SIGNED`=1, zero-extended otherwise.
- Reduction levels:
  - Each level groups rows in threes from index 0 upward into CSAs.
  - Each CSA produces sum row and carry row; the carry row is shifted left 1 and truncated to `OW`.
  - Leftover rows (n mod 3) pass through unchanged.
  - Level outputs are registered.
- Final stage adds the last two rows with a `OW`-bit adder and registers the result into `out_sum`.
- If `CHANNELS`=2, `STAGES`=0 and the pipeline is the CPA register only.
- Each pipeline register has a valid bit. Advance enable is `adv = !out_valid || out_ready`. It is a global stall: all stages hold when `adv`=0.
- `in_ready = adv`. A transfer occurs when `in_valid && in_ready`. When `in_valid`=0 and `adv`=1, a bubble (valid=0) enters stage 1.
- An output transfer occurs when `out_valid && out_ready`.
- `out_sum` and all stage data hold their values while stalled. Data of invalid stages is don't-care, but the registers are cleared by reset.

## Timing
- Latency: `STAGES`+1 cycles from input transfer to `out_valid`, assuming no stall. For 10×6 this is 4 cycles.
- Throughput: one operand set per cycle while `out_ready`=1. No bubbles are inserted.
- Stalls add cycles 1:1 to latency. No data is lost or duplicated.
- Reset values:
  - `out_valid`=0, `out_sum`=0, `busy`=0
  - all stage valid bits and data = 0
  - `in_ready`=1 (combinational from `out_valid`=0)
- Reset mid-operation: all in-flight sets are discarded immediately (asynchronous). The first transfer after `rst` deasserts is the first result out.
- Simultaneous output transfer and new input with a full pipeline is legal. Every stage advances and occupancy is unchanged.
- `in_valid` while `in_ready`=0: no transfer. The producer must hold `in_data`. The block ignores it.
- Overflow is impossible by construction of `OW` for either signedness.

## Configuration
- `WALLACE_RESULT_CNT_EN` defined:
  - Adds output port `result_cnt` [15:0].
  - It increments on each output transfer and wraps 16'hFFFF→0.
  - Reset value is 0.
- Not defined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- `WIDTH`=10, `CHANNELS`=6, `SIGNED`=0, all operands 1023, `out_ready`=1 -> `out_sum`=6138 (13'h17FA) with `out_valid` exactly 4 cycles after the transfer.
- `SIGNED`=1, all six operands 10'h3FF (−1) -> `out_sum`=13'h1FFA (−6). Operands {511,−512,0,0,0,0} -> 13'h1FFF (−1).
- Streaming: 100 consecutive random sets with `out_ready`=1 -> 100 results in order, one per cycle after a 4-cycle fill, each matching a reference sum.
- Backpressure: random `out_ready` with 30% low, random `in_valid` -> `in_ready` equals `!out_valid || out_ready` each cycle. No result is lost, duplicated or reordered. `out_sum` is stable while stalled.
- Reset mid-stream: assert `rst` with 3 sets in flight -> `out_valid`, `busy` and `out_sum` are 0 in the same cycle. After release, only sets transferred after reset appear.
- Edge configs: `CHANNELS`=2 (latency 1), `CHANNELS`=3 (latency 2) and `CHANNELS`=9 (latency 5) give correct sums of max values. With the macro defined, `result_cnt` reads 100 after 100 transfers and wraps correctly after forcing to 16'hFFFF.
